// File: rtl/vending_ctrl_param_if.sv
`default_nettype none
// ============================================================================
// Module      : vending_ctrl_param_if
// Description : Front-end / back-end signal bundle of the vending controller.
//               The master side is the keypad, coin acceptor and restock
//               port; the slave side is the transaction controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface vending_ctrl_param_if #(
  parameter int ID_W  = 4,
  parameter int VAL_W = 8
);
  // Front-end requests
  logic             id_typed;
  logic [ID_W-1:0]  id_in;
  logic [VAL_W-1:0] price_in;
  logic             coin_valid;
  logic [VAL_W-1:0] coin_val;
  logic             cancel;
  logic             restock;
  logic [ID_W-1:0]  restock_id;
  // Back-end results
  logic [ID_W-1:0]  sel_id;
  logic [VAL_W-1:0] credit;
  logic             release_product;
  logic             back_money;
  logic [VAL_W-1:0] change_val;
  logic [1:0]       error_code;
  logic [2:0]       state_now;

  modport master (
    output id_typed, id_in, price_in, coin_valid, coin_val, cancel,
           restock, restock_id,
    input  sel_id, credit, release_product, back_money, change_val,
           error_code, state_now
  );

  modport slave (
    input  id_typed, id_in, price_in, coin_valid, coin_val, cancel,
           restock, restock_id,
    output sel_id, credit, release_product, back_money, change_val,
           error_code, state_now
  );
endinterface
`default_nettype wire

// File: rtl/vending_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module      : vending_ctrl_param
// Description : Parametrised vending transaction controller. Validates a
//               keyed product ID, accumulates coins with saturation, then
//               dispenses with change or refunds, holding each result for
//               SHOW_CYC cycles. Keeps a saturating stock count per product.
// Revision    : 1.0 - initial release
// ============================================================================
module vending_ctrl_param #(
  parameter int NUM_PRODUCTS = 10,
  parameter int ID_W         = 4,
  parameter int VAL_W        = 8,
  parameter int STOCK_W      = 4,
  parameter int INIT_STOCK   = 5,
  parameter int TIMEOUT_CYC  = 1000,
  parameter int SHOW_CYC     = 8
) (
  input  logic                clk,
  input  logic                rst,
  vending_ctrl_param_if.slave bus
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam int SHW_W = (SHOW_CYC > 1) ? $clog2(SHOW_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'b000,
    S_VALIDATE  = 3'b001,
    S_COLLECT   = 3'b010,
    S_ALL_OK    = 3'b011,
    S_ERR_ID    = 3'b100,
    S_ERR_MONEY = 3'b101,
    S_ERR_STOCK = 3'b110
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [ID_W-1:0]    r_sel_id, w_sel_id_nxt;
  logic [VAL_W-1:0]   r_credit, w_credit_nxt;
  logic [VAL_W-1:0]   r_price, w_price_nxt;
  logic [VAL_W-1:0]   r_change, w_change_nxt;
  logic               r_release, w_release_nxt;
  logic               r_back, w_back_nxt;
  logic [1:0]         r_err, w_err_nxt;
  logic [TMR_W-1:0]   r_timer, w_timer_nxt;
  logic [SHW_W-1:0]   r_show, w_show_nxt;
  logic               w_dispense;

  logic [STOCK_W-1:0] r_stock [NUM_PRODUCTS];
  logic [STOCK_W-1:0] w_sel_stock;
  logic [NUM_PRODUCTS-1:0] w_inc, w_dec;

  logic [VAL_W-1:0]   w_coin;
  logic [VAL_W:0]     w_sum;
  logic [VAL_W-1:0]   w_nc;
  logic [VAL_W-1:0]   w_paid_change;
  logic               w_bad_id;

  // Credit after this cycle's coin, pinned at full scale instead of wrapping
  assign w_coin        = bus.coin_valid ? bus.coin_val : '0;
  assign w_sum         = {1'b0, r_credit} + {1'b0, w_coin};
  assign w_nc          = w_sum[VAL_W] ? '1 : w_sum[VAL_W-1:0];
  assign w_paid_change = w_nc - r_price;
  // Extra bit so the compare stays correct when NUM_PRODUCTS == 2^ID_W
  assign w_bad_id      = ({1'b0, r_sel_id} >= (ID_W+1)'(NUM_PRODUCTS));

  // Per-slot restock/dispense strobes and stock lookup for the selected ID
  always_comb begin
    w_sel_stock = '0;
    w_inc       = '0;
    w_dec       = '0;
    for (int i = 0; i < NUM_PRODUCTS; i++) begin
      w_inc[i] = bus.restock && (bus.restock_id == ID_W'(i));
      w_dec[i] = w_dispense && (r_sel_id == ID_W'(i));
      if (r_sel_id == ID_W'(i)) w_sel_stock = r_stock[i];
    end
  end

  // Next-state and next-output logic of the transaction sequencer
  always_comb begin
    w_state_nxt   = r_state;
    w_sel_id_nxt  = r_sel_id;
    w_credit_nxt  = r_credit;
    w_price_nxt   = r_price;
    w_change_nxt  = r_change;
    w_release_nxt = r_release;
    w_back_nxt    = r_back;
    w_err_nxt     = r_err;
    w_timer_nxt   = r_timer;
    w_show_nxt    = r_show;
    w_dispense    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.id_typed) begin
          w_sel_id_nxt = bus.id_in;
          w_state_nxt  = S_VALIDATE;
        end
      end
      S_VALIDATE: begin
        w_show_nxt = SHW_W'(SHOW_CYC - 1);
        if (w_bad_id) begin
          w_state_nxt  = S_ERR_ID;
          w_err_nxt    = 2'd1;
          w_change_nxt = '0;
          w_back_nxt   = 1'b0;
        end else if (w_sel_stock == '0) begin
          w_state_nxt  = S_ERR_STOCK;
          w_err_nxt    = 2'd2;
          w_change_nxt = '0;
          w_back_nxt   = 1'b0;
        end else begin
          w_state_nxt  = S_COLLECT;
          w_price_nxt  = bus.price_in;
          w_credit_nxt = '0;
          w_timer_nxt  = TMR_W'(TIMEOUT_CYC);
        end
      end
      S_COLLECT: begin
        w_credit_nxt = w_nc;
        w_show_nxt   = SHW_W'(SHOW_CYC - 1);
        if (bus.coin_valid)
          w_timer_nxt = TMR_W'(TIMEOUT_CYC);
        else if (r_timer != '0)
          w_timer_nxt = r_timer - 1'b1;
        if (bus.cancel) begin
          // A coin arriving with the cancel is returned along with the rest
          w_state_nxt  = S_ERR_MONEY;
          w_change_nxt = w_nc;
          w_back_nxt   = (w_nc != '0);
          w_err_nxt    = 2'd3;
        end else if (w_nc >= r_price) begin
          w_state_nxt   = S_ALL_OK;
          w_change_nxt  = w_paid_change;
          w_back_nxt    = (w_paid_change != '0);
          w_release_nxt = 1'b1;
          w_dispense    = 1'b1;
        end else if (!bus.coin_valid && (r_timer <= TMR_W'(1))) begin
          w_state_nxt  = S_ERR_MONEY;
          w_change_nxt = r_credit;
          w_back_nxt   = (r_credit != '0);
          w_err_nxt    = 2'd3;
        end
      end
      S_ALL_OK, S_ERR_ID, S_ERR_MONEY, S_ERR_STOCK: begin
        if (r_show == '0) begin
          w_state_nxt   = S_IDLE;
          w_credit_nxt  = '0;
          w_change_nxt  = '0;
          w_err_nxt     = 2'd0;
          w_release_nxt = 1'b0;
          w_back_nxt    = 1'b0;
        end else begin
          w_show_nxt = r_show - 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Sequencer state, timers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_sel_id  <= '0;
      r_credit  <= '0;
      r_price   <= '0;
      r_change  <= '0;
      r_release <= 1'b0;
      r_back    <= 1'b0;
      r_err     <= 2'd0;
      r_timer   <= '0;
      r_show    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_sel_id  <= w_sel_id_nxt;
      r_credit  <= w_credit_nxt;
      r_price   <= w_price_nxt;
      r_change  <= w_change_nxt;
      r_release <= w_release_nxt;
      r_back    <= w_back_nxt;
      r_err     <= w_err_nxt;
      r_timer   <= w_timer_nxt;
      r_show    <= w_show_nxt;
    end
  end

  // Stock counters: saturating restock, dispense on ALL_OK entry, both cancel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PRODUCTS; i++)
        r_stock[i] <= STOCK_W'(INIT_STOCK);
    end else begin
      for (int i = 0; i < NUM_PRODUCTS; i++) begin
        if (w_inc[i] && !w_dec[i]) begin
          if (r_stock[i] != '1) r_stock[i] <= r_stock[i] + 1'b1;
        end else if (w_dec[i] && !w_inc[i]) begin
          r_stock[i] <= r_stock[i] - 1'b1;
        end
      end
    end
  end

  assign bus.sel_id          = r_sel_id;
  assign bus.credit          = r_credit;
  assign bus.release_product = r_release;
  assign bus.back_money      = r_back;
  assign bus.change_val      = r_change;
  assign bus.error_code      = r_err;
  assign bus.state_now       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_vending_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_vending_ctrl_param
// Description : Directed self-checking bench for vending_ctrl_param.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vending_ctrl_param;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  logic [7:0] price_tab [16];

  vending_ctrl_param_if #(.ID_W(4), .VAL_W(8)) vif ();

  vending_ctrl_param #(
    .NUM_PRODUCTS(10), .ID_W(4), .VAL_W(8), .STOCK_W(4),
    .INIT_STOCK(2), .TIMEOUT_CYC(20), .SHOW_CYC(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(vif)
  );

  // External price table indexed by the latched product ID
  assign vif.price_in = price_tab[vif.sel_id];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Key an ID and step through VALIDATE_ID
  task automatic start(input logic [3:0] id);
    vif.id_typed = 1'b1;
    vif.id_in    = id;
    tick();
    vif.id_typed = 1'b0;
    tick();
  endtask

  task automatic coin(input logic [7:0] v);
    vif.coin_valid = 1'b1;
    vif.coin_val   = v;
    tick();
    vif.coin_valid = 1'b0;
  endtask

  // Measure how long the current result state lasts, then check IDLE cleanup
  task automatic hold_len(input string tag, input int exp);
    int         n;
    logic [2:0] s;
    s = vif.state_now;
    n = 1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (vif.state_now != s) break;
      n++;
    end
    check({tag, "_len"}, n, exp);
    check({tag, "_idle"}, {29'd0, vif.state_now}, 0);
    check({tag, "_clr"}, {10'd0, vif.credit, vif.change_val, vif.error_code,
                          vif.release_product, vif.back_money}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 16; i++) price_tab[i] = 8'd0;
    price_tab[0] = 8'd4;
    price_tab[1] = 8'd6;
    price_tab[2] = 8'd7;
    price_tab[3] = 8'd5;
    price_tab[5] = 8'd255;
    vif.id_typed = 1'b0; vif.id_in = '0; vif.coin_valid = 1'b0; vif.coin_val = '0;
    vif.cancel = 1'b0; vif.restock = 1'b0; vif.restock_id = '0;
    rst = 1'b1;
    #12;
    check("rst_state", {29'd0, vif.state_now}, 0);
    check("rst_outs", {10'd0, vif.credit, vif.change_val, vif.error_code,
                       vif.release_product, vif.back_money}, 0);
    for (int i = 0; i < 10; i++) check("rst_stock", {28'd0, dut.r_stock[i]}, 2);
    rst = 1'b0;
    tick();

    // Exact pay
    start(4'd3);
    check("exact_collect", {29'd0, vif.state_now}, 2);
    coin(8'd2);
    check("exact_credit", {24'd0, vif.credit}, 2);
    check("exact_wait", {29'd0, vif.state_now}, 2);
    coin(8'd3);
    check("exact_state", {29'd0, vif.state_now}, 3);
    check("exact_rel", {31'd0, vif.release_product}, 1);
    check("exact_chg", {24'd0, vif.change_val}, 0);
    check("exact_back", {31'd0, vif.back_money}, 0);
    check("exact_stock", {28'd0, dut.r_stock[3]}, 1);
    hold_len("exact", 4);

    // Overpay
    start(4'd1);
    coin(8'd5);
    coin(8'd5);
    check("over_state", {29'd0, vif.state_now}, 3);
    check("over_chg", {24'd0, vif.change_val}, 4);
    check("over_back", {31'd0, vif.back_money}, 1);
    hold_len("over", 4);

    // Bad ID
    start(4'd12);
    check("badid_state", {29'd0, vif.state_now}, 4);
    check("badid_err", {30'd0, vif.error_code}, 1);
    check("badid_back", {31'd0, vif.back_money}, 0);
    hold_len("badid", 4);

    // Exhaust product 0, then restock
    for (int b = 0; b < 2; b++) begin
      start(4'd0);
      coin(8'd4);
      check("buy0_state", {29'd0, vif.state_now}, 3);
      hold_len("buy0", 4);
    end
    check("buy0_stock", {28'd0, dut.r_stock[0]}, 0);
    start(4'd0);
    check("nostock_state", {29'd0, vif.state_now}, 6);
    check("nostock_err", {30'd0, vif.error_code}, 2);
    hold_len("nostock", 4);
    vif.restock = 1'b1; vif.restock_id = 4'd0;
    tick();
    vif.restock = 1'b0;
    check("restock_cnt", {28'd0, dut.r_stock[0]}, 1);
    start(4'd0);
    coin(8'd4);
    check("restock_buy", {29'd0, vif.state_now}, 3);
    hold_len("restock_buy", 4);

    // Timeout after 20 coin-less cycles
    start(4'd2);
    coin(8'd3);
    repeat (19) tick();
    check("to_before", {29'd0, vif.state_now}, 2);
    tick();
    check("to_state", {29'd0, vif.state_now}, 5);
    check("to_err", {30'd0, vif.error_code}, 3);
    check("to_refund", {24'd0, vif.change_val}, 3);
    check("to_back", {31'd0, vif.back_money}, 1);
    hold_len("to", 4);

    // Cancel with a coin in the same cycle
    start(4'd2);
    vif.coin_valid = 1'b1; vif.coin_val = 8'd2; vif.cancel = 1'b1;
    tick();
    vif.coin_valid = 1'b0; vif.cancel = 1'b0;
    check("cancel_state", {29'd0, vif.state_now}, 5);
    check("cancel_refund", {24'd0, vif.change_val}, 2);
    check("cancel_err", {30'd0, vif.error_code}, 3);
    hold_len("cancel", 4);

    // Asynchronous reset mid-COLLECT
    start(4'd2);
    coin(8'd4);
    check("prerst_credit", {24'd0, vif.credit}, 4);
    #2 rst = 1'b1;
    #1;
    check("arst_state", {29'd0, vif.state_now}, 0);
    check("arst_outs", {6'd0, vif.sel_id, vif.credit, vif.change_val, vif.error_code,
                        vif.release_product, vif.back_money}, 0);
    check("arst_stock3", {28'd0, dut.r_stock[3]}, 2);
    check("arst_stock0", {28'd0, dut.r_stock[0]}, 2);
    #2 rst = 1'b0;
    tick();

    // Saturation and id_typed during COLLECT
    start(4'd5);
    coin(8'd200);
    check("sat_credit1", {24'd0, vif.credit}, 200);
    vif.id_typed = 1'b1; vif.id_in = 4'd7;
    tick();
    vif.id_typed = 1'b0;
    check("sat_selid", {28'd0, vif.sel_id}, 5);
    check("sat_still", {29'd0, vif.state_now}, 2);
    coin(8'd200);
    check("sat_credit2", {24'd0, vif.credit}, 255);
    check("sat_state", {29'd0, vif.state_now}, 3);
    check("sat_chg", {24'd0, vif.change_val}, 0);
    hold_len("sat", 4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
